// File: rtl/uart_byte_collector.sv
// Assembles sampler bit pulses into bytes and queues good frames in a small FWFT FIFO.
// Bad frames and overruns are reported through err_pulse, err_cnt and a sticky overrun flag.
module uart_byte_collector #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          align,
    input  logic                          bit_valid,
    input  logic                          bit_data,
    input  logic                          frame_done,
    input  logic                          framing_error,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          err_pulse,
    output logic                          overrun,
    input  logic                          clr_err,
    output logic [7:0]                    err_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam logic [FW-1:0] FULL_CNT = FW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, COMPLETE} state_t;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          bad;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic frame_good;
    logic push_req;
    logic bad_frame;
    logic full;
    logic pop;
    logic push_ok;
    logic drop;
    logic [7:0] err_base;

    always_comb begin
        frame_good = (state == COMPLETE) && !framing_error && !bad;
        push_req   = frame_done && frame_good;
        bad_frame  = frame_done && !frame_good;
        full       = (fill == FULL_CNT);
        m_valid    = (fill != '0);
        m_data     = mem[rd_ptr];
        pop        = m_valid && m_ready;
        // A pop in the same cycle frees the slot the push needs.
        push_ok    = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        err_base   = clr_err ? 8'd0 : err_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            shreg   <= 8'd0;
            bad     <= 1'b0;
        end else if (align) begin
            state   <= COLLECT;
            bit_cnt <= 4'd0;
            bad     <= 1'b0;
        end else if (frame_done) begin
            state <= IDLE;
            bad   <= 1'b0;
        end else if (bit_valid) begin
            case (state)
                COLLECT: begin
                    shreg   <= {bit_data, shreg[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        state <= COMPLETE;
                    end
                end
                COMPLETE: bad <= 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= 8'd0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                fill <= fill + FW'(1);
            end else if (pop && !push_ok) begin
                fill <= fill - FW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse <= 1'b0;
            overrun   <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            err_pulse <= bad_frame || drop;
            // Clear takes effect first so a coincident error still registers.
            overrun   <= (overrun && !clr_err) || drop;
            if (bad_frame && err_base != 8'hFF) begin
                err_cnt <= err_base + 8'd1;
            end else begin
                err_cnt <= err_base;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_collector.sv
// Directed bench for uart_byte_collector: frame assembly, FIFO full/overrun and error paths.
module tb_uart_byte_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       align = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_data = 1'b0;
    logic       frame_done = 1'b0;
    logic       framing_error = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [2:0] fill;
    logic       err_pulse;
    logic       overrun;
    logic       clr_err = 1'b0;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    uart_byte_collector #(.FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .align         (align),
        .bit_valid     (bit_valid),
        .bit_data      (bit_data),
        .frame_done    (frame_done),
        .framing_error (framing_error),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .fill          (fill),
        .err_pulse     (err_pulse),
        .overrun       (overrun),
        .clr_err       (clr_err),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_data  = b[i % 8];
            tick();
        end
        bit_valid = 1'b0;
        bit_data  = 1'b0;
    endtask

    task automatic do_align();
        align = 1'b1;
        tick();
        align = 1'b0;
    endtask

    task automatic do_frame_done(input logic fe, input logic rdy);
        frame_done    = 1'b1;
        framing_error = fe;
        m_ready       = rdy;
        tick();
        frame_done    = 1'b0;
        framing_error = 1'b0;
        m_ready       = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic fe, input logic rdy);
        do_align();
        send_bits(b, 8);
        do_frame_done(fe, rdy);
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'h00);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Good frame 0xA5
        send_frame(8'hA5, 1'b0, 1'b0);
        check("a5_m_valid", 32'(m_valid), 32'd1);
        check("a5_m_data", 32'(m_data), 32'hA5);
        check("a5_fill", 32'(fill), 32'd1);
        check("a5_err_pulse", 32'(err_pulse), 32'd0);
        pop_one();
        check("a5_pop_fill", 32'(fill), 32'd0);
        check("a5_pop_valid", 32'(m_valid), 32'd0);

        // Framing error
        send_frame(8'hA5, 1'b1, 1'b0);
        check("fe_err_pulse", 32'(err_pulse), 32'd1);
        check("fe_err_cnt", 32'(err_cnt), 32'd1);
        check("fe_fill", 32'(fill), 32'd0);
        tick();
        check("fe_pulse_end", 32'(err_pulse), 32'd0);

        // Overrun with depth 4
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b0);
        end
        check("ovr_fill", 32'(fill), 32'd4);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_err_pulse", 32'(err_pulse), 32'd1);
        check("ovr_err_cnt", 32'(err_cnt), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_pop_data", 32'(m_data), 32'(i));
            pop_one();
        end
        check("ovr_drained", 32'(fill), 32'd0);

        // Full with simultaneous pop
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_overrun", 32'(overrun), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b0, 1'b0);
        end
        check("full_fill", 32'(fill), 32'd4);
        send_frame(8'h05, 1'b0, 1'b1);
        check("fpop_fill", 32'(fill), 32'd4);
        check("fpop_overrun", 32'(overrun), 32'd0);
        check("fpop_err_pulse", 32'(err_pulse), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            check("fpop_data", 32'(m_data), 32'(i));
            pop_one();
        end
        check("fpop_drained", 32'(fill), 32'd0);

        // Start glitch: realign mid-byte
        do_align();
        send_bits(8'b0000_0011, 3);
        send_frame(8'hFF, 1'b0, 1'b0);
        check("glitch_fill", 32'(fill), 32'd1);
        check("glitch_data", 32'(m_data), 32'hFF);
        check("glitch_err_pulse", 32'(err_pulse), 32'd0);
        check("glitch_err_cnt", 32'(err_cnt), 32'd0);
        pop_one();

        // Reset mid-frame
        do_reset();
        do_align();
        send_bits(8'h0F, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_bits(8'hF0, 4);
        do_frame_done(1'b0, 1'b0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd1);
        check("midrst_fill", 32'(fill), 32'd0);
        check("midrst_err_pulse", 32'(err_pulse), 32'd1);

        // Ninth bit marks the frame bad
        do_align();
        send_bits(8'h3C, 9);
        do_frame_done(1'b0, 1'b0);
        check("ninth_err_cnt", 32'(err_cnt), 32'd2);
        check("ninth_fill", 32'(fill), 32'd0);

        // frame_done in IDLE, then coincident clear and error
        do_frame_done(1'b0, 1'b0);
        check("idle_fd_err_cnt", 32'(err_cnt), 32'd3);
        clr_err = 1'b1;
        do_frame_done(1'b0, 1'b0);
        clr_err = 1'b0;
        check("clr_coinc_err_cnt", 32'(err_cnt), 32'd1);

        // m_ready while empty has no effect
        pop_one();
        check("empty_pop_fill", 32'(fill), 32'd0);
        check("empty_pop_valid", 32'(m_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
